// File: rtl/s_check_pkg.sv
// s_check_pkg: shared ARC4 definitions for the S-memory checker.
//   state_t   : checker FSM states (IDLE, READ, DRAIN)
//   N_ENTRIES : number of S-memory bytes swept (256)
//   ADDR_W    : S-memory address width (8)
package s_check_pkg;

    localparam int N_ENTRIES = 256;
    localparam int ADDR_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/s_check.sv
// s_check: reader counterpart of the S-init writer. It sweeps a
// synchronous-read S-memory and checks s[i] == i for every entry.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   en             start request, sampled only while rdy=1
//   rdy            idle and able to accept en
//   addr           S-memory read address
//   rddata         S-memory read data, valid one cycle after addr
//   done           a sweep has completed, results valid
//   pass           registered: done with err_count == 0
//   err_count      mismatching entries in the last sweep (0..256)
//   first_bad_addr lowest mismatching address, 0 when none
//   state          current FSM state (debug visibility)
//
// Handshake: en is a level request qualified by rdy. A start happens on
// the rising edge where rdy=1 and en=1; en while rdy=0 is dropped, not
// queued. rst wins over en.
module s_check #(
    parameter int N_ENTRIES = s_check_pkg::N_ENTRIES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    output logic                            rdy,
    output logic [s_check_pkg::ADDR_W-1:0]  addr,
    input  logic [s_check_pkg::ADDR_W-1:0]  rddata,
    output logic                            done,
    output logic                            pass,
    output logic [s_check_pkg::ADDR_W:0]    err_count,
    output logic [s_check_pkg::ADDR_W-1:0]  first_bad_addr,
    output s_check_pkg::state_t             state
);

    import s_check_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ENTRIES - 1);

    state_t            state_q;
    state_t            state_d;

    // One-stage delay register: the address whose data arrives this cycle.
    logic [ADDR_W-1:0] dly_addr;
    logic              dly_vld;
    logic              mismatch;

    assign mismatch = dly_vld && (rddata != dly_addr);
    assign rdy      = (state_q == IDLE);
    assign state    = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = READ;
            READ:    if (addr == LAST_ADDR) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr           <= '0;
            dly_addr       <= '0;
            dly_vld        <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_bad_addr <= '0;
        end else begin
            // Data for the address presented in a READ cycle arrives in the
            // following cycle, so the valid flag trails the READ state by one.
            dly_vld <= (state_q == READ);

            if (state_q == READ) begin
                dly_addr <= addr;
                // Returning to 0 after the last entry leaves addr=0 in DRAIN/IDLE.
                addr     <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
            end

            if (mismatch) begin
                err_count <= err_count + (ADDR_W+1)'(1);
                if (err_count == '0) begin
                    first_bad_addr <= dly_addr;
                end
            end

            if (state_q == IDLE && en) begin
                done           <= 1'b0;
                pass           <= 1'b0;
                err_count      <= '0;
                first_bad_addr <= '0;
            end

            // DRAIN carries the final comparison, so pass must fold it in.
            if (state_q == DRAIN) begin
                done <= 1'b1;
                pass <= (err_count == '0) && !mismatch;
            end
        end
    end

endmodule

// File: tb/tb_s_check.sv
// tb_s_check: directed bench for s_check with a behavioural 256x8
// synchronous-read RAM and an address-sequence monitor.
module tb_s_check;

    import s_check_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] addr;
    logic [7:0] rddata;
    logic       done;
    logic       pass;
    logic [8:0] err_count;
    logic [7:0] first_bad_addr;
    state_t     state;

    int n_checks = 0;
    int n_errors = 0;

    s_check dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .rdy            (rdy),
        .addr           (addr),
        .rddata         (rddata),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_bad_addr (first_bad_addr),
        .state          (state)
    );

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    // ---------------- memory model ----------------
    logic [7:0] mem [256];
    always @(posedge clk) rddata <= mem[addr];

    task automatic fill_identity();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // ---------------- address monitor ----------------
    state_t     prev_state = IDLE;
    logic [7:0] exp_addr = 8'h00;
    int         mon_err = 0;
    int         sweeps = 0;

    always @(negedge clk) begin
        if (!rst && state == READ) begin
            if (prev_state != READ) begin
                exp_addr = 8'h00;
                sweeps++;
            end else begin
                exp_addr = exp_addr + 8'h01;
            end
            if (addr !== exp_addr) mon_err++;
        end
        prev_state = state;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts a sweep from IDLE and counts negedges until rdy returns.
    // n is 1 on the negedge right after the accepting edge E, so the
    // first negedge showing rdy=1 after edge E+257 yields n=258, i.e.
    // the edge E+258 is the first to sample rdy=1.
    task automatic run_sweep(input bit hold, input bit repulse, output int n);
        en = 1'b1;
        @(negedge clk);
        if (!hold) en = 1'b0;
        check("start_rdy_low", 32'(rdy), 32'd0);
        check("start_done_clr", 32'(done), 32'd0);
        n = 1;
        while (!rdy && n < 1000) begin
            @(negedge clk);
            n++;
            if (repulse && n == 50) en = 1'b1;
            if (repulse && n == 51) en = 1'b0;
        end
        if (n >= 1000) check("sweep_timeout", 32'(n), 32'd258);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int s0;

        fill_identity();
        do_reset();

        // reset state
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_rdy", 32'(rdy), 32'd1);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_fba", 32'(first_bad_addr), 32'd0);

        // identity memory
        run_sweep(1'b0, 1'b0, n);
        check("id_lat", 32'(n), 32'd258);
        check("id_done", 32'(done), 32'd1);
        check("id_pass", 32'(pass), 32'd1);
        check("id_err", 32'(err_count), 32'd0);
        check("id_fba", 32'(first_bad_addr), 32'd0);
        repeat (5) @(negedge clk);
        check("id_hold_done", 32'(done), 32'd1);
        check("id_hold_pass", 32'(pass), 32'd1);
        check("idle_addr", 32'(addr), 32'd0);

        // two corrupted entries
        mem[17]  = 8'h00;
        mem[200] = 8'hFF;
        run_sweep(1'b0, 1'b0, n);
        check("two_lat", 32'(n), 32'd258);
        check("two_err", 32'(err_count), 32'd2);
        check("two_fba", 32'(first_bad_addr), 32'd17);
        check("two_pass", 32'(pass), 32'd0);
        check("two_done", 32'(done), 32'd1);

        // all zero: only entry 0 matches
        fill_zero();
        run_sweep(1'b0, 1'b0, n);
        check("zero_err", 32'(err_count), 32'd255);
        check("zero_fba", 32'(first_bad_addr), 32'd1);
        check("zero_pass", 32'(pass), 32'd0);

        // en re-pulsed mid-sweep is ignored
        fill_identity();
        run_sweep(1'b0, 1'b1, n);
        check("repulse_lat", 32'(n), 32'd258);
        check("repulse_pass", 32'(pass), 32'd1);
        @(negedge clk);
        check("repulse_no_queue", 32'(rdy), 32'd1);

        // back-to-back sweeps with en held high
        s0 = sweeps;
        run_sweep(1'b1, 1'b0, n);
        check("b2b_lat0", 32'(n), 32'd258);
        check("b2b_pass0", 32'(pass), 32'd1);
        for (int k = 1; k < 3; k++) begin
            if (k == 2) begin
                n = 0;
            end
            @(negedge clk);
            check("b2b_gap", 32'(rdy), 32'd0);
            check("b2b_done_clr", 32'(done), 32'd0);
            n = 1;
            while (!rdy && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (k == 2) en = 1'b0;
            check("b2b_lat", 32'(n), 32'd258);
            check("b2b_pass", 32'(pass), 32'd1);
        end
        @(negedge clk);
        check("b2b_stop", 32'(rdy), 32'd1);
        check("b2b_sweeps", 32'(sweeps - s0), 32'd3);

        // reset mid-sweep with en held high
        fill_zero();
        en = 1'b1;
        repeat (100) @(negedge clk);
        check("mid_busy", 32'(rdy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_state", 32'(state), 32'(IDLE));
        check("mid_rdy", 32'(rdy), 32'd1);
        check("mid_addr", 32'(addr), 32'd0);
        check("mid_err", 32'(err_count), 32'd0);
        check("mid_fba", 32'(first_bad_addr), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_pass", 32'(pass), 32'd0);
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        check("mid_stay_idle", 32'(rdy), 32'd1);

        // one clean sweep after the abort
        fill_identity();
        run_sweep(1'b0, 1'b0, n);
        check("post_lat", 32'(n), 32'd258);
        check("post_pass", 32'(pass), 32'd1);

        check("addr_seq", 32'(mon_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/s_check.md
S_CHECK -- requirements
Module: s_check

Interface
REQ-001 Parameter N_ENTRIES, default 256, number of S-memory bytes swept; fixed at 256 for this design.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  start request; sampled only when rdy=1.
REQ-005 rdy  output  1  high when idle and able to accept en.
REQ-006 addr  output  8  S-memory read address.
REQ-007 rddata  input  8  S-memory read data; valid one cycle after addr is presented (synchronous-read RAM).
REQ-008 done  output  1  high once a sweep has completed; results valid.
REQ-009 pass  output  1  high when done=1 and err_count=0.
REQ-010 err_count  output  9  number of mismatching entries in the last sweep (0..256).
REQ-011 first_bad_addr  output  8  address of the lowest mismatching entry; 0 when err_count=0.

Function
REQ-012 Block SHALL be the reader counterpart of the S-init writer: it SHALL check s[i]==i for i=0..255.
REQ-013 States SHALL be IDLE, READ and DRAIN only.
REQ-014 IDLE: rdy=1, addr=0, and results held; en=1 SHALL move to READ next cycle, clearing done, pass, err_count and first_bad_addr.
REQ-015 en while rdy=0 SHALL be ignored; it is not queued.
REQ-016 READ: addr SHALL equal 0 in the first READ cycle and increment by 1 each cycle; after the cycle presenting addr=255, state SHALL go to DRAIN.
REQ-017 Each cycle after an address is presented, rddata SHALL be compared with that address, held in a one-stage delay register; READ SHALL sustain one read per cycle (pipelined).
REQ-018 DRAIN SHALL last one cycle, compare the data for addr=255, and then go to IDLE with done=1.
REQ-019 Latency: en accepted at edge E. Then rdy=0 from E+1, and rdy=1 and done=1 from E+258.
REQ-020 On a mismatch, err_count SHALL increment by 1; it SHALL not wrap, because the 9-bit width covers 256.
REQ-021 first_bad_addr SHALL capture the address of the first mismatch only; later mismatches SHALL not overwrite it.
REQ-022 pass SHALL be registered and SHALL equal done AND (err_count==0) as of the final comparison.
REQ-023 en=1 in the first IDLE cycle after completion SHALL start a new sweep. The done/pass results are then visible for exactly that one cycle.
REQ-024 The block SHALL never write memory; addr SHALL be the only memory-side output.

Reset
REQ-025 rst=1 SHALL force the following values at the next edge, from any state including mid-sweep: state=IDLE, rdy=1, addr=0, done=0, pass=0, err_count=0, first_bad_addr=0, delay register=0.
REQ-026 rst SHALL take priority over en in the same cycle.

Structure
REQ-027 The shared ARC4 package SHALL hold the state enum (IDLE, READ, DRAIN) and the constants N_ENTRIES=256 and ADDR_W=8.
REQ-028 The block SHALL be a single module with no sub-module; the memory is instantiated outside it and connected via addr/rddata.

Verification
REQ-029 Bench SHALL use a behavioural 256x8 synchronous-read RAM model and the standard 50 MHz-style clk.
REQ-030 Memory s[i]=i, rst, then pulse en one cycle -> rdy=0 next cycle, rdy=1 exactly 258 cycles after acceptance, done=1, pass=1, err_count=0, first_bad_addr=0.
REQ-031 s[i]=i except s[17]=0x00 and s[200]=0xFF -> err_count=2, first_bad_addr=17, pass=0, done=1.
REQ-032 All bytes 0x00 -> err_count=255, first_bad_addr=1, pass=0.
REQ-033 en held high continuously -> back-to-back sweeps with rdy=1 for exactly one cycle between them; addr sequence 0..255 each sweep, checked by a monitor.
REQ-034 rst asserted at cycle 100 of a sweep with en held high -> next cycle state=IDLE, rdy=1, addr=0, err_count=0, done=0, pass=0.
REQ-035 en re-pulsed while rdy=0 -> ignored; completion timing unchanged at 258 cycles.
